sram_port_arbiter: RTL and testbench

- Shares the single 32-bit-word SRAM controller between two word-access requesters: port 0 = MEM stage data accesses, port 1 = secondary master (instruction fetch / debug loader).
- Sits between the requesters and the SRAM controller's word interface.
- Translates byte addresses to SRAM halfword addresses, serializes accesses and grants ties round-robin.
- Produces a per-port ready; each requester freezes on ~pN_ready.

---
 rtl/sram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the SRAM controller word interface.
// Port 0 is the MEM stage and port 1 is the secondary master. Accesses are
// serialized, ties alternate round-robin, and byte addresses are converted
// to SRAM halfword addresses. A requester holds while its ready is low.
module sram_port_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'd1024,
   parameter int          ADDR_W    = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_rd_en,
   input  logic              p0_wr_en,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic [31:0]       p0_rdata,
   output logic              p0_ready,
   input  logic              p1_rd_en,
   input  logic              p1_wr_en,
   input  logic [31:0]       p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic [31:0]       p1_rdata,
   output logic              p1_ready,
   output logic              mc_rd_en,
   output logic              mc_wr_en,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [31:0]       mc_wdata,
   input  logic [31:0]       mc_rdata,
   input  logic              mc_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t            state;
   logic              last_grant;
   logic              op_wr;
   logic [31:0]       rdata_reg0;
   logic [31:0]       rdata_reg1;

   logic              req0;
   logic              req1;
   logic              pick1;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic              done0;
   logic              done1;

   // Byte address to halfword address; addresses below the base wrap around.
   function automatic logic [ADDR_W-1:0] to_halfword(input logic [31:0] byte_addr);
      return ADDR_W'(((byte_addr - BASE_ADDR) >> 2) << 1);
   endfunction

   assign req0  = p0_rd_en | p0_wr_en;
   assign req1  = p1_rd_en | p1_wr_en;
   assign done0 = (state == BUSY0) && mc_ready;
   assign done1 = (state == BUSY1) && mc_ready;

   // Pick the port to grant from IDLE: a lone requester wins, a tie goes to
   // the port that did not win last time.
   always_comb begin
      pick1     = req1 & (~req0 | ~last_grant);
      sel_wr    = pick1 ? p1_wr_en : p0_wr_en;
      sel_addr  = pick1 ? to_halfword(p1_addr) : to_halfword(p0_addr);
      sel_wdata = pick1 ? p1_wdata : p0_wdata;
   end

   // Arbitration FSM; controller outputs only change from latched state so
   // requester activity during a transaction cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_wr      <= 1'b0;
         mc_rd_en   <= 1'b0;
         mc_wr_en   <= 1'b0;
         mc_addr    <= '0;
         mc_wdata   <= '0;
         rdata_reg0 <= '0;
         rdata_reg1 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  state      <= pick1 ? BUSY1 : BUSY0;
                  last_grant <= pick1;
                  op_wr      <= sel_wr;
                  mc_rd_en   <= ~sel_wr;
                  mc_wr_en   <= sel_wr;
                  mc_addr    <= sel_addr;
                  mc_wdata   <= sel_wdata;
               end
            end
            BUSY0: begin
               if (mc_ready) begin
                  state    <= IDLE;
                  mc_rd_en <= 1'b0;
                  mc_wr_en <= 1'b0;
                  if (!op_wr) begin
                     rdata_reg0 <= mc_rdata;
                  end
               end
            end
            BUSY1: begin
               if (mc_ready) begin
                  state    <= IDLE;
                  mc_rd_en <= 1'b0;
                  mc_wr_en <= 1'b0;
                  if (!op_wr) begin
                     rdata_reg1 <= mc_rdata;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               mc_rd_en <= 1'b0;
               mc_wr_en <= 1'b0;
            end
         endcase
      end
   end

   // Ready and read data back to the requesters; read data is bypassed in
   // the completion cycle so the requester can use it without an extra wait.
   always_comb begin
      p0_ready = ~req0 | done0;
      p1_ready = ~req1 | done1;
      p0_rdata = (done0 && !op_wr) ? mc_rdata : rdata_reg0;
      p1_rdata = (done1 && !op_wr) ? mc_rdata : rdata_reg1;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: plays the SRAM controller, drives the two
// requesters and checks controller-side and requester-side behaviour.
module tb_sram_port_arbiter;

   logic        clk;
   logic        rst;
   logic        p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [31:0] p0_rdata, p1_rdata;
   logic        p0_ready, p1_ready;
   logic        mc_rd_en, mc_wr_en;
   logic [17:0] mc_addr;
   logic [31:0] mc_wdata;
   logic [31:0] mc_rdata;
   logic        mc_ready;

   int tests;
   int failed;

   typedef struct {
      int          port;
      logic        wr;
      logic [17:0] addr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      int          port;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rval;
      logic        exp_wr;
      logic [17:0] exp_addr;
   } vec_t;

   exp_t        sb[$];
   logic [31:0] exp_rdata [2];
   vec_t        vecs [6];

   sram_port_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .p0_rd_en (p0_rd_en),
      .p0_wr_en (p0_wr_en),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p0_rdata (p0_rdata),
      .p0_ready (p0_ready),
      .p1_rd_en (p1_rd_en),
      .p1_wr_en (p1_wr_en),
      .p1_addr  (p1_addr),
      .p1_wdata (p1_wdata),
      .p1_rdata (p1_rdata),
      .p1_ready (p1_ready),
      .mc_rd_en (mc_rd_en),
      .mc_wr_en (mc_wr_en),
      .mc_addr  (mc_addr),
      .mc_wdata (mc_wdata),
      .mc_rdata (mc_rdata),
      .mc_ready (mc_ready)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input int port, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         p0_rd_en = rd; p0_wr_en = wr; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_rd_en = rd; p1_wr_en = wr; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   task automatic release_port(input int port);
      if (port == 0) begin
         p0_rd_en = 1'b0; p0_wr_en = 1'b0;
      end else begin
         p1_rd_en = 1'b0; p1_wr_en = 1'b0;
      end
   endtask

   // Wait for the next grant, match it against the scoreboard head, act as
   // the controller for 'waits' stall cycles and then complete it.
   task automatic serve(input int waits, input logic [31:0] rval, input bit keep, input bit perturb);
      exp_t e;
      bit   found;
      logic own_ready, other_ready, other_req;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mc_rd_en || mc_wr_en) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!found) begin
         check_output("grant_timeout", 32'd0, 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check_output("unexpected_grant", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      for (int c = 0; c <= waits; c++) begin
         if (c == waits) begin
            mc_ready = 1'b1;
            mc_rdata = rval;
         end
         if (perturb && c == 0) begin
            apply_stimulus(e.port, 1'b1, 1'b1, 32'd2048, 32'hFFFF_FFFF);
         end
         #4;
         check_output("mc_addr", 32'(mc_addr), 32'(e.addr));
         check_output("mc_wdata", mc_wdata, e.wdata);
         check_output("mc_wr_en", 32'(mc_wr_en), 32'(e.wr));
         check_output("mc_rd_en", 32'(mc_rd_en), 32'(!e.wr));
         own_ready   = (e.port == 0) ? p0_ready : p1_ready;
         other_ready = (e.port == 0) ? p1_ready : p0_ready;
         other_req   = (e.port == 0) ? (p1_rd_en | p1_wr_en) : (p0_rd_en | p0_wr_en);
         check_output("own_ready", 32'(own_ready), 32'(c == waits));
         check_output("other_ready", 32'(other_ready), 32'(!other_req));
         if (c == waits) begin
            check_output("done_rdata", (e.port == 0) ? p0_rdata : p1_rdata,
                         e.wr ? exp_rdata[e.port] : rval);
         end
         @(posedge clk); #1;
      end
      mc_ready = 1'b0;
      mc_rdata = 32'd0;
      if (!e.wr) begin
         exp_rdata[e.port] = rval;
      end
      if (!keep) begin
         release_port(e.port);
      end
      check_output("idle_enables", 32'({mc_rd_en, mc_wr_en}), 32'd0);
      check_output("held_rdata", (e.port == 0) ? p0_rdata : p1_rdata, exp_rdata[e.port]);
   endtask

   initial begin
      tests = 0;
      failed = 0;
      exp_rdata[0] = 32'd0;
      exp_rdata[1] = 32'd0;
      rst = 1'b1;
      mc_ready = 1'b0;
      mc_rdata = 32'd0;
      apply_stimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
      apply_stimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);

      vecs[0] = '{0, 1'b1, 1'b0, 32'd1028, 32'h0000_0011, 4, 32'hDEAD_BEEF, 1'b0, 18'd2};
      vecs[1] = '{0, 1'b1, 1'b1, 32'd1024, 32'hA5A5_5A5A, 1, 32'h0,         1'b1, 18'd0};
      vecs[2] = '{0, 1'b1, 1'b0, 32'd1020, 32'h0000_0022, 2, 32'h1357_9BDF, 1'b0, 18'h3FFFE};
      vecs[3] = '{1, 1'b1, 1'b0, 32'd1036, 32'h0000_0033, 0, 32'h2468_ACE0, 1'b0, 18'd6};
      vecs[4] = '{0, 1'b0, 1'b1, 32'd4096, 32'h0BAD_F00D, 3, 32'h0,         1'b1, 18'h600};
      vecs[5] = '{1, 1'b1, 1'b0, 32'd1280, 32'h0000_0044, 2, 32'hCAFE_F00D, 1'b0, 18'd128};

      repeat (2) @(posedge clk);
      #1;
      check_output("rst_enables", 32'({mc_rd_en, mc_wr_en}), 32'd0);
      check_output("rst_mc_addr", 32'(mc_addr), 32'd0);
      check_output("rst_mc_wdata", mc_wdata, 32'd0);
      check_output("rst_p0_rdata", p0_rdata, 32'd0);
      check_output("rst_p1_rdata", p1_rdata, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         #4;
         check_output("idle_p0_ready", 32'(p0_ready), 32'd1);
         check_output("idle_p1_ready", 32'(p1_ready), 32'd1);
         @(posedge clk); #1;
      end

      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         sb.push_back('{vecs[i].port, vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].wdata});
         #4;
         check_output("req_idle_ready", 32'((vecs[i].port == 0) ? p0_ready : p1_ready), 32'd0);
         @(posedge clk); #1;
         serve(vecs[i].waits, vecs[i].rval, 1'b0, 1'b0);
      end

      apply_stimulus(1, 1'b0, 1'b1, 32'd1032, 32'h1234_5678);
      sb.push_back('{1, 1'b1, 18'd4, 32'h1234_5678});
      serve(3, 32'h7777_7777, 1'b0, 1'b1);

      apply_stimulus(0, 1'b1, 1'b0, 32'd1100, 32'h0000_0055);
      apply_stimulus(1, 1'b1, 1'b0, 32'd1200, 32'h0000_0066);
      sb.push_back('{0, 1'b0, 18'd38, 32'h0000_0055});
      sb.push_back('{1, 1'b0, 18'd88, 32'h0000_0066});
      serve(1, 32'h1111_0000, 1'b0, 1'b0);
      #4;
      check_output("gap_p1_ready", 32'(p1_ready), 32'd0);
      @(posedge clk); #1;
      serve(2, 32'h2222_0000, 1'b0, 1'b0);

      apply_stimulus(0, 1'b1, 1'b0, 32'd1040, 32'h0000_0077);
      apply_stimulus(1, 1'b1, 1'b0, 32'd1048, 32'h0000_0088);
      sb.push_back('{0, 1'b0, 18'd8,  32'h0000_0077});
      sb.push_back('{1, 1'b0, 18'd12, 32'h0000_0088});
      sb.push_back('{0, 1'b0, 18'd8,  32'h0000_0077});
      sb.push_back('{1, 1'b0, 18'd12, 32'h0000_0088});
      serve(1, 32'hA000_0001, 1'b1, 1'b0);
      serve(1, 32'hA000_0002, 1'b1, 1'b0);
      serve(0, 32'hA000_0003, 1'b0, 1'b0);
      serve(2, 32'hA000_0004, 1'b0, 1'b0);

      apply_stimulus(0, 1'b1, 1'b0, 32'd1060, 32'h0000_0099);
      @(posedge clk); #1;
      check_output("pre_rst_busy", 32'(mc_rd_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      apply_stimulus(1, 1'b1, 1'b0, 32'd1064, 32'h0000_00AA);
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      exp_rdata[0] = 32'd0;
      exp_rdata[1] = 32'd0;
      check_output("midrst_enables", 32'({mc_rd_en, mc_wr_en}), 32'd0);
      check_output("midrst_mc_addr", 32'(mc_addr), 32'd0);
      check_output("midrst_mc_wdata", mc_wdata, 32'd0);
      check_output("midrst_p0_rdata", p0_rdata, 32'd0);
      check_output("midrst_p1_rdata", p1_rdata, 32'd0);
      check_output("midrst_p0_ready", 32'(p0_ready), 32'd0);
      sb.push_back('{0, 1'b0, 18'd18, 32'h0000_0099});
      sb.push_back('{1, 1'b0, 18'd20, 32'h0000_00AA});
      serve(1, 32'h5555_AAAA, 1'b0, 1'b0);
      serve(0, 32'hAAAA_5555, 1'b0, 1'b0);

      check_output("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
